fifo_sync_flags: RTL and testbench

- Parametrised single-clock first-word-fall-through FIFO; next generation of the team's basic FIFO.
- Adds arbitrary depth (non-power-of-2), an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Adds push-while-full when a pop occurs in the same cycle.
- Sits between producer/consumer stages in the datapath as the standard buffering primitive.

---
 rtl/fifo_sync_flags.sv | 135 +++++++++++++
 tb/tb_fifo_sync_flags.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags
//   Single-clock first-word-fall-through FIFO of arbitrary depth. The
//   pointers wrap at DEPTH-1, so the depth need not be a power of two. It
//   provides an occupancy count, programmable almost-full and almost-empty
//   thresholds, and sticky overflow/underflow error flags. A push into a
//   full FIFO is accepted when a valid pop happens in the same cycle.
//
//   Optional feature: define FIFO_FLUSH_EN to add the `flush` input. A flush
//   zeroes the pointers and the count and overrides push/pop in that cycle.
//   It does not clear the storage or the sticky flags.
//
// Ports
//   clk          in   rising-edge clock
//   rstn         in   asynchronous active-low reset
//   push         in   write request
//   data         in   [WIDTH] write data
//   pop          in   read request, consumes current head
//   clr_err      in   synchronous clear of overflow/underflow
//   flush        in   (FIFO_FLUSH_EN only) empty the FIFO
//   out          out  [WIDTH] head entry, '0 when empty
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  [$clog2(DEPTH+1)] occupancy
//   overflow     out  sticky, a push was rejected
//   underflow    out  sticky, a pop was rejected
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  input  logic             clr_err,
`ifdef FIFO_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    push_ptr;
  logic [PW-1:0]    pop_ptr;

  logic pop_avail;
  logic push_avail;
  logic pop_ok;
  logic push_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Acceptance is decided from the registered count. A pop on an empty FIFO
  // is never bypassed to a same-cycle push.
  assign pop_avail  = pop && !empty;
  assign push_avail = push && (!full || pop_avail);

`ifdef FIFO_FLUSH_EN
  assign pop_ok  = pop_avail && !flush;
  assign push_ok = push_avail && !flush;
`else
  assign pop_ok  = pop_avail;
  assign push_ok = push_avail;
`endif

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign out          = empty ? '0 : mem[pop_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[push_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_ptr <= '0;
      pop_ptr  <= '0;
      count    <= '0;
    end else begin
`ifdef FIFO_FLUSH_EN
      if (flush) begin
        push_ptr <= '0;
        pop_ptr  <= '0;
        count    <= '0;
      end else
`endif
      begin
        if (push_ok) push_ptr <= next_ptr(push_ptr);
        if (pop_ok)  pop_ptr  <= next_ptr(pop_ptr);
        if (push_ok && !pop_ok)      count <= count + 1'b1;
        else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_avail) overflow <= 1'b1;
      else if (clr_err)        overflow <= 1'b0;
      if (pop && !pop_avail)   underflow <= 1'b1;
      else if (clr_err)        underflow <= 1'b0;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
    count <= CW'(DEPTH));
  a_full_empty: assert property (@(posedge clk) disable iff (!rstn)
    !(full && empty));

endmodule

// File: tb/tb_fifo_sync_flags.sv
module tb_fifo_sync_flags;

  localparam int W  = 4;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          push;
  logic [W-1:0]  data;
  logic          pop;
  logic          clr_err;
`ifdef FIFO_FLUSH_EN
  logic          flush;
`endif
  logic [W-1:0]  out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .push(push),
    .data(data),
    .pop(pop),
    .clr_err(clr_err),
`ifdef FIFO_FLUSH_EN
    .flush(flush),
`endif
    .out(out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_out"}, 32'(out), 0);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_unf"}, 32'(underflow), 0);
  endtask

  initial begin
    rstn = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data = '0;
`ifdef FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    tick(); tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk_reset_state("rst");

    // fill 1..5
    push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data = W'(i);
      tick();
      chk($sformatf("fill%0d_count", i), 32'(count), i);
      chk($sformatf("fill%0d_out", i), 32'(out), 1);
      chk($sformatf("fill%0d_af", i), 32'(almost_full), (i >= 4) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), 32'(full), (i == 5) ? 1 : 0);
      chk($sformatf("fill%0d_ae", i), 32'(almost_empty), (i <= 1) ? 1 : 0);
    end

    // push into full without pop
    data = 4'hF;
    tick();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 5);
    chk("ovf_out", 32'(out), 1);

    // push while full with simultaneous pop
    data = 4'd6; pop = 1'b1;
    tick();
    chk("pp_full_out", 32'(out), 2);
    chk("pp_full_count", 32'(count), 5);
    chk("pp_full_full", 32'(full), 1);
    chk("pp_full_ovf_sticky", 32'(overflow), 1);

    // drain, crossing the wrap from index 4 back to 0
    push = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain%0d_out", k), 32'(out), k + 2);
      tick();
    end
    pop = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_out", 32'(out), 0);
    chk("drain_count", 32'(count), 0);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);

    // empty with push and pop together: push accepted, pop rejected
    push = 1'b1; pop = 1'b1; data = 4'd9;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("ep_count", 32'(count), 1);
    chk("ep_out", 32'(out), 9);
    chk("ep_unf", 32'(underflow), 1);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unf_clear", 32'(underflow), 0);

    pop = 1'b1;
    tick();
    chk("pop9_empty", 32'(empty), 1);
    chk("pop9_unf", 32'(underflow), 0);

    // clear and new error in the same cycle: set wins
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0; pop = 1'b0;
    chk("clr_vs_set_unf", 32'(underflow), 1);
    tick();
    chk("unf_sticky", 32'(underflow), 1);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unf_clear2", 32'(underflow), 0);

    // pop on empty alone, then push 7
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop_empty_unf", 32'(underflow), 1);
    chk("pop_empty_count", 32'(count), 0);
    push = 1'b1; data = 4'd7;
    tick();
    push = 1'b0;
    chk("push7_out", 32'(out), 7);
    chk("push7_count", 32'(count), 1);

    // fill to 3 entries, then assert reset between edges
    push = 1'b1;
    data = 4'd8; tick();
    data = 4'd9; tick();
    push = 1'b0;
    chk("three_count", 32'(count), 3);
    chk("three_out", 32'(out), 7);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_out", 32'(out), 0);

`ifdef FIFO_FLUSH_EN
    push = 1'b1;
    data = 4'd1; tick();
    data = 4'd2; tick();
    data = 4'd3; tick();
    chk("pre_flush_count", 32'(count), 3);
    data = 4'd4; flush = 1'b1;
    tick();
    flush = 1'b0; push = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_out", 32'(out), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
